// File: rtl/bicubic_window_gen_pkg.sv
// Shared constants for the bicubic window generator: default geometry and window shape.
// The frame geometry is the padded input size; windows only form once four rows and columns exist.
package bicubic_window_gen_pkg;

  localparam int CHANNEL_WIDTH_DEF = 8;
  localparam int IMG_WIDTH_DEF     = 960;
  localparam int IMG_HEIGHT_DEF    = 540;

  localparam int WIN_DIM  = 4;
  localparam int LB_COUNT = WIN_DIM - 1;

  // Number of fully populated 4x4 windows in one padded frame.
  function automatic int win_count(input int width, input int height);
    return (width - (WIN_DIM - 1)) * (height - (WIN_DIM - 1));
  endfunction

endpackage

// File: rtl/bicubic_window_gen_if.sv
// Bundle of the pixel input stream, the window output handshake and the status pulses.
// The slave modport is the generator's view; master is the surrounding system.
interface bicubic_window_gen_if
  import bicubic_window_gen_pkg::*;
#(
  parameter int CHANNEL_WIDTH = CHANNEL_WIDTH_DEF
);

  logic                     pix_valid;
  logic                     pix_ready;
  logic [CHANNEL_WIDTH-1:0] pix_data;
  logic                     pix_sof;

  logic                     bf_req_valid;
  logic                     bcci_req_ready;
  logic [CHANNEL_WIDTH-1:0] p1, p2, p3, p4, p5, p6, p7, p8;
  logic [CHANNEL_WIDTH-1:0] p9, p10, p11, p12, p13, p14, p15, p16;

  logic                     frame_done;
  logic                     sof_err;

  modport master (
    output pix_valid, pix_data, pix_sof, bcci_req_ready,
    input  pix_ready, bf_req_valid,
    input  p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15, p16,
    input  frame_done, sof_err
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, bcci_req_ready,
    output pix_ready, bf_req_valid,
    output p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15, p16,
    output frame_done, sof_err
  );

endinterface

// File: rtl/bicubic_line_buf.sv
// One row of pixel history: single address for write and read, asynchronous read that
// returns the old contents when written in the same cycle. Contents are never reset.
module bicubic_line_buf
  import bicubic_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH = CHANNEL_WIDTH_DEF,
  parameter int DEPTH      = IMG_WIDTH_DEF,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bicubic_window_gen.sv
// Raster pixel stream to 4x4 source windows for the 2x bicubic upsampler: three line buffers
// supply the three older rows of the current column, a shift register holds the last four columns.
module bicubic_window_gen
  import bicubic_window_gen_pkg::*;
#(
  parameter int CHANNEL_WIDTH = CHANNEL_WIDTH_DEF,
  parameter int IMG_WIDTH     = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT    = IMG_HEIGHT_DEF,
  parameter int CW            = $clog2(IMG_WIDTH),
  parameter int RW            = $clog2(IMG_HEIGHT)
) (
  input logic                clk,
  input logic                rst,
  bicubic_window_gen_if.slave bus
);

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;
  logic          valid_reg;
  logic          frame_done_reg;
  logic          sof_err_reg;

  logic pix_ready;
  logic acc;
  logic out_hs;
  logic col_last;
  logic row_last;
  logic qualify;
  logic lb_we;

  logic [CHANNEL_WIDTH-1:0] lb_rd   [LB_COUNT];
  logic [CHANNEL_WIDTH-1:0] lb_wr   [LB_COUNT];
  logic [CHANNEL_WIDTH-1:0] col_vec [WIN_DIM];
  logic [CHANNEL_WIDTH-1:0] win_reg [WIN_DIM][WIN_DIM];

  // A held window is never overwritten: input stalls exactly while the output is stalled.
  assign pix_ready = ~valid_reg | bus.bcci_req_ready;
  assign acc       = bus.pix_valid & pix_ready;
  assign out_hs    = valid_reg & bus.bcci_req_ready;

  // A start-of-frame pixel is placed at (0,0) regardless of where the counters were.
  assign col_eff  = bus.pix_sof ? '0 : col_reg;
  assign row_eff  = bus.pix_sof ? '0 : row_reg;
  assign col_last = (col_eff == CW'(IMG_WIDTH - 1));
  assign row_last = (row_eff == RW'(IMG_HEIGHT - 1));
  assign qualify  = (row_eff >= RW'(WIN_DIM - 1)) && (col_eff >= CW'(WIN_DIM - 1));
  assign lb_we    = acc & ~rst;

  // Line buffer 0 takes the incoming pixel; each later buffer takes what the previous one held.
  for (genvar gi = 0; gi < LB_COUNT; gi++) begin : g_lb
    if (gi == 0) begin : g_head
      assign lb_wr[gi] = bus.pix_data;
    end else begin : g_chain
      assign lb_wr[gi] = lb_rd[gi-1];
    end

    bicubic_line_buf #(
      .DATA_WIDTH (CHANNEL_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .AW         (CW)
    ) u_line_buf (
      .clk   (clk),
      .we    (lb_we),
      .addr  (col_eff),
      .wdata (lb_wr[gi]),
      .rdata (lb_rd[gi])
    );

    // Row 0 of the window is the oldest line, i.e. the last buffer in the chain.
    assign col_vec[gi] = lb_rd[LB_COUNT-1-gi];
  end

  assign col_vec[WIN_DIM-1] = bus.pix_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg        <= '0;
      row_reg        <= '0;
      valid_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      sof_err_reg    <= 1'b0;
    end else begin
      frame_done_reg <= acc & col_last & row_last;
      sof_err_reg    <= acc & bus.pix_sof & ((col_reg != '0) | (row_reg != '0));
      if (acc) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_eff + RW'(1);
        end else begin
          col_reg <= col_eff + CW'(1);
          row_reg <= row_eff;
        end
        valid_reg <= qualify;
      end else if (out_hs) begin
        valid_reg <= 1'b0;
      end
    end
  end

  // Shift left on every accepted pixel, including row starts, so the window is full by col 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else if (acc) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM - 1; c++) begin
          win_reg[r][c] <= win_reg[r][c+1];
        end
        win_reg[r][WIN_DIM-1] <= col_vec[r];
      end
    end
  end

  assign bus.pix_ready    = pix_ready;
  assign bus.bf_req_valid = valid_reg;
  assign bus.frame_done   = frame_done_reg;
  assign bus.sof_err      = sof_err_reg;

  assign bus.p1  = win_reg[0][0];
  assign bus.p2  = win_reg[0][1];
  assign bus.p3  = win_reg[0][2];
  assign bus.p4  = win_reg[0][3];
  assign bus.p5  = win_reg[1][0];
  assign bus.p6  = win_reg[1][1];
  assign bus.p7  = win_reg[1][2];
  assign bus.p8  = win_reg[1][3];
  assign bus.p9  = win_reg[2][0];
  assign bus.p10 = win_reg[2][1];
  assign bus.p11 = win_reg[2][2];
  assign bus.p12 = win_reg[2][3];
  assign bus.p13 = win_reg[3][0];
  assign bus.p14 = win_reg[3][1];
  assign bus.p15 = win_reg[3][2];
  assign bus.p16 = win_reg[3][3];

endmodule

// File: tb/tb_bicubic_window_gen.sv
// Directed bench for bicubic_window_gen on a 6x5 frame: a reference image model fills a
// window scoreboard on each accepted pixel and every output handshake pops and compares.
module tb_bicubic_window_gen;
  import bicubic_window_gen_pkg::*;

  localparam int W  = 6;
  localparam int H  = 5;
  localparam int DW = 8;
  localparam int WV = 16 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bicubic_window_gen_if #(.CHANNEL_WIDTH(DW)) bus ();

  bicubic_window_gen #(
    .CHANNEL_WIDTH (DW),
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  logic [WV-1:0] sb_q[$];
  logic [WV-1:0] win_log[$];
  logic [DW-1:0] img [H][W];
  int            mrow = 0, mcol = 0;
  logic          exp_valid = 1'b0, exp_fd = 1'b0, exp_se = 1'b0, exp_clear = 1'b0;
  int            n_win = 0, n_fd = 0, n_se = 0, n_stall = 0, run = 0, max_run = 0;
  logic [WV-1:0] cur, held, exp_w;
  logic          stalled = 1'b0;
  logic          hs, m_acc;
  int            er, ec;

  function automatic logic [DW-1:0] pk(input logic [WV-1:0] v, input int k);
    return v[(16-k)*DW +: DW];
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard and cycle model: compare what the DUT shows now, then predict the next cycle.
  always @(negedge clk) begin
    cur = {bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8,
           bus.p9, bus.p10, bus.p11, bus.p12, bus.p13, bus.p14, bus.p15, bus.p16};
    if (rst) begin
      mrow = 0; mcol = 0;
      exp_valid = 1'b0; exp_fd = 1'b0; exp_se = 1'b0;
      exp_clear = 1'b1; stalled = 1'b0; run = 0;
      sb_q.delete();
    end else begin
      checks++;
      assert (bus.bf_req_valid === exp_valid) else begin
        errors++; $error("FAIL bf_req_valid observed=%b expected=%b", bus.bf_req_valid, exp_valid);
      end
      checks++;
      assert (bus.frame_done === exp_fd) else begin
        errors++; $error("FAIL frame_done observed=%b expected=%b", bus.frame_done, exp_fd);
      end
      checks++;
      assert (bus.sof_err === exp_se) else begin
        errors++; $error("FAIL sof_err observed=%b expected=%b", bus.sof_err, exp_se);
      end
      checks++;
      assert (bus.pix_ready === (!exp_valid || bus.bcci_req_ready)) else begin
        errors++; $error("FAIL pix_ready observed=%b expected=%b", bus.pix_ready,
                         (!exp_valid || bus.bcci_req_ready));
      end
      if (exp_clear) begin
        checks++;
        assert (cur === '0) else begin
          errors++; $error("FAIL reset_window observed=%h expected=0", cur);
        end
        exp_clear = 1'b0;
      end
      if (bus.frame_done === 1'b1) n_fd++;
      if (bus.sof_err === 1'b1) n_se++;
      run = (bus.bf_req_valid === 1'b1) ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (stalled && bus.bf_req_valid === 1'b1) begin
        checks++;
        assert (cur === held) else begin
          errors++; $error("FAIL stall_hold observed=%h expected=%h", cur, held);
        end
      end
      stalled = (bus.bf_req_valid === 1'b1) && !bus.bcci_req_ready;
      if (stalled) n_stall++;
      held = cur;

      hs = (bus.bf_req_valid === 1'b1) && bus.bcci_req_ready;
      if (hs) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $error("FAIL window_unexpected observed=%h expected=none", cur);
        end else begin
          exp_w = sb_q.pop_front();
          assert (cur === exp_w) else begin
            errors++; $error("FAIL window observed=%h expected=%h", cur, exp_w);
          end
        end
        win_log.push_back(cur);
        n_win++;
        $display("window %0d: p1=%0d p4=%0d p13=%0d p16=%0d", n_win,
                 pk(cur, 1), pk(cur, 4), pk(cur, 13), pk(cur, 16));
      end

      m_acc  = bus.pix_valid && bus.pix_ready;
      exp_fd = 1'b0;
      exp_se = 1'b0;
      if (m_acc) begin
        er = bus.pix_sof ? 0 : mrow;
        ec = bus.pix_sof ? 0 : mcol;
        exp_se = bus.pix_sof && (mrow != 0 || mcol != 0);
        img[er][ec] = bus.pix_data;
        if (er >= 3 && ec >= 3) begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              exp_w[(15-(4*r+c))*DW +: DW] = img[er-3+r][ec-3+c];
          sb_q.push_back(exp_w);
          exp_valid = 1'b1;
        end else begin
          exp_valid = 1'b0;
        end
        exp_fd = (er == H-1) && (ec == W-1);
        if (ec == W-1) begin
          mcol = 0;
          mrow = (er == H-1) ? 0 : er + 1;
        end else begin
          mcol = ec + 1;
          mrow = er;
        end
      end else if (hs) begin
        exp_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.bcci_req_ready = 1'b1;
      1:       bus.bcci_req_ready = ~bus.bcci_req_ready;
      default: bus.bcci_req_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
  endtask

  task automatic send(input int v, input bit sof, input bit rnd);
    int  n = 0;
    bit  done = 1'b0;
    bit  now;
    while (!done && n < 200) begin
      bus.pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_data  = DW'(v);
      bus.pix_sof   = sof;
      now = bus.pix_valid && bus.pix_ready;
      tick();
      done = now;
      n++;
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic send_frame(input int offset, input bit rnd);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(10*r + c + offset, (r == 0 && c == 0), rnd);
  endtask

  task automatic drain();
    ready_mode = 0;
    repeat (6) tick();
  endtask

  int base, fd0, se0, st0;

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_sof   = 1'b0;
    bus.bcci_req_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset held two cycles in the middle of a partial frame.
    for (int i = 0; i < 8; i++) send(10*(i/W) + (i%W), 1'b0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_no_window", n_win, 0);

    // Full frame with the core always ready; includes back-to-back windows in row 3.
    base = n_win; fd0 = n_fd; max_run = 0;
    send_frame(0, 1'b0);
    drain();
    check("frame1_windows", n_win - base, win_count(W, H));
    check("frame1_done", n_fd - fd0, 1);
    check("first_p1", int'(pk(win_log[base], 1)), 0);
    check("first_p4", int'(pk(win_log[base], 4)), 3);
    check("first_p13", int'(pk(win_log[base], 13)), 30);
    check("first_p16", int'(pk(win_log[base], 16)), 33);
    check("b2b_p16_col4", int'(pk(win_log[base+1], 16)), 34);
    check("b2b_p16_col5", int'(pk(win_log[base+2], 16)), 35);
    check("b2b_valid_run", max_run, 3);

    // Core alternating ready/not-ready.
    base = n_win; fd0 = n_fd; st0 = n_stall;
    ready_mode = 1;
    send_frame(0, 1'b0);
    drain();
    check("alt_windows", n_win - base, win_count(W, H));
    check("alt_done", n_fd - fd0, 1);
    check("alt_stalls_seen", int'(n_stall > st0), 1);

    // Start-of-frame in the middle of row 2 restarts the frame.
    base = n_win; se0 = n_se; fd0 = n_fd;
    for (int i = 0; i < 2*W + 4; i++) send(10*(i/W) + (i%W), 1'b0, 1'b0);
    check("pre_sof_windows", n_win - base, 0);
    send_frame(100, 1'b0);
    drain();
    check("sof_err_pulses", n_se - se0, 1);
    check("sof_windows", n_win - base, win_count(W, H));
    check("sof_first_p1", int'(pk(win_log[base], 1)), 100);
    check("sof_done", n_fd - fd0, 1);

    // Two frames with random pixel gaps and random core readiness.
    base = n_win; fd0 = n_fd;
    ready_mode = 2;
    send_frame(50, 1'b1);
    send_frame(150, 1'b1);
    drain();
    check("two_frame_windows", n_win - base, 2 * win_count(W, H));
    check("two_frame_done", n_fd - fd0, 2);
    check("frameA_first_p1", int'(pk(win_log[base], 1)), 50);
    check("frameB_first_p1", int'(pk(win_log[base+6], 1)), 150);
    check("frameB_first_p16", int'(pk(win_log[base+6], 16)), 183);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
